// File: rtl/lcd_dither_if.sv
// Pixel bus into and out of the LCD dither stage: syncs, data enable and RGB colour.
// The slave modport is the dither stage's view; the master modport drives it and observes it.
interface lcd_dither_if;
  logic       iHD;
  logic       iVD;
  logic       iDEN;
  logic [7:0] iLCD_R;
  logic [7:0] iLCD_G;
  logic [7:0] iLCD_B;
  logic       iBYPASS;
  logic       oHD;
  logic       oVD;
  logic       oDEN;
  logic [5:0] oLCD_R;
  logic [5:0] oLCD_G;
  logic [5:0] oLCD_B;

  modport slave (
    input  iHD, iVD, iDEN, iLCD_R, iLCD_G, iLCD_B, iBYPASS,
    output oHD, oVD, oDEN, oLCD_R, oLCD_G, oLCD_B
  );

  modport master (
    output iHD, iVD, iDEN, iLCD_R, iLCD_G, iLCD_B, iBYPASS,
    input  oHD, oVD, oDEN, oLCD_R, oLCD_G, oLCD_B
  );
endinterface

// File: rtl/lcd_dither_stage.sv
// Ordered-dither reduction of 8-bit RGB to 6-bit panel data, two-cycle pipeline.
// Define TEMPORAL_DITHER_EN to rotate the dither matrix phase every frame.
module lcd_dither_stage #(
  parameter int MATRIX_SIZE = 4
) (
  input  logic         iCLK,
  input  logic         iRST_n,
  lcd_dither_if.slave  pix
);

  // Ordered-dither offset; the 4x4 Bayer entries are scaled down by 4.
  function automatic logic [1:0] dither_lut(input logic [1:0] xi, input logic [1:0] yi);
    logic [3:0] bayer_v;
    bayer_v = 4'd0;
    if (MATRIX_SIZE == 2) begin
      case ({yi[0], xi[0]})
        2'b00:   bayer_v = 4'd0;
        2'b01:   bayer_v = 4'd8;
        2'b10:   bayer_v = 4'd12;
        2'b11:   bayer_v = 4'd4;
        default: bayer_v = 4'd0;
      endcase
    end else begin
      case ({yi, xi})
        4'd0:    bayer_v = 4'd0;
        4'd1:    bayer_v = 4'd8;
        4'd2:    bayer_v = 4'd2;
        4'd3:    bayer_v = 4'd10;
        4'd4:    bayer_v = 4'd12;
        4'd5:    bayer_v = 4'd4;
        4'd6:    bayer_v = 4'd14;
        4'd7:    bayer_v = 4'd6;
        4'd8:    bayer_v = 4'd3;
        4'd9:    bayer_v = 4'd11;
        4'd10:   bayer_v = 4'd1;
        4'd11:   bayer_v = 4'd9;
        4'd12:   bayer_v = 4'd15;
        4'd13:   bayer_v = 4'd7;
        4'd14:   bayer_v = 4'd13;
        4'd15:   bayer_v = 4'd5;
        default: bayer_v = 4'd0;
      endcase
    end
    return bayer_v[3:2];
  endfunction

  // The 9-bit sum reaches bit 8 only when (v + d) >> 2 would be 64.
  function automatic logic [5:0] dither_sat(input logic [7:0] v, input logic [1:0] d);
    logic [8:0] sum_v;
    sum_v = {1'b0, v} + {7'd0, d};
    if (sum_v[8]) begin
      return 6'd63;
    end else begin
      return sum_v[7:2];
    end
  endfunction

  logic       den_prev_r;
  logic       vd_prev_r;
  logic [1:0] xc_r;
  logic [1:0] yc_r;
  logic       den_fall_s;
  logic       vd_fall_s;
  logic [1:0] xi_s;
  logic [1:0] yi_s;

  logic       hd1_r, vd1_r, den1_r, byp1_r;
  logic [7:0] r1_r, g1_r, b1_r;
  logic [1:0] d1_r;
  logic [5:0] r_s, g_s, b_s;
  logic       hd2_r, vd2_r, den2_r;
  logic [5:0] r2_r, g2_r, b2_r;

  assign den_fall_s = den_prev_r & ~pix.iDEN;
  assign vd_fall_s  = vd_prev_r & ~pix.iVD;

`ifdef TEMPORAL_DITHER_EN
  logic [1:0] fc_r;

  // Frame counter advances on every vertical sync falling edge.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      fc_r <= 2'd0;
    end else if (vd_fall_s) begin
      fc_r <= fc_r + 2'd1;
    end else begin
      fc_r <= fc_r;
    end
  end

  // Matrix index rotated by the frame phase.
  always_comb begin
    xi_s = xc_r ^ {1'b0, fc_r[0]};
    yi_s = yc_r ^ {1'b0, fc_r[1]};
  end
`else
  // Matrix index follows the screen position directly.
  always_comb begin
    xi_s = xc_r;
    yi_s = yc_r;
  end
`endif

  // Edge-detect copies and column/row position counters; a frame start beats a line end.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      den_prev_r <= 1'b0;
      vd_prev_r  <= 1'b0;
      xc_r       <= 2'd0;
      yc_r       <= 2'd0;
    end else begin
      den_prev_r <= pix.iDEN;
      vd_prev_r  <= pix.iVD;
      if (pix.iDEN) begin
        xc_r <= xc_r + 2'd1;
      end else begin
        xc_r <= 2'd0;
      end
      if (vd_fall_s) begin
        yc_r <= 2'd0;
      end else if (den_fall_s) begin
        yc_r <= yc_r + 2'd1;
      end else begin
        yc_r <= yc_r;
      end
    end
  end

  // Stage 1: capture syncs, pixel, bypass and the offset for this pixel's position.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      hd1_r  <= 1'b0;
      vd1_r  <= 1'b0;
      den1_r <= 1'b0;
      byp1_r <= 1'b0;
      r1_r   <= 8'd0;
      g1_r   <= 8'd0;
      b1_r   <= 8'd0;
      d1_r   <= 2'd0;
    end else begin
      hd1_r  <= pix.iHD;
      vd1_r  <= pix.iVD;
      den1_r <= pix.iDEN;
      byp1_r <= pix.iBYPASS;
      r1_r   <= pix.iLCD_R;
      g1_r   <= pix.iLCD_G;
      b1_r   <= pix.iLCD_B;
      d1_r   <= dither_lut(xi_s, yi_s);
    end
  end

  // Dither or truncate, and blank the colour whenever the pixel is not enabled.
  always_comb begin
    r_s = 6'd0;
    g_s = 6'd0;
    b_s = 6'd0;
    if (!den1_r) begin
      r_s = 6'd0;
      g_s = 6'd0;
      b_s = 6'd0;
    end else if (byp1_r) begin
      r_s = r1_r[7:2];
      g_s = g1_r[7:2];
      b_s = b1_r[7:2];
    end else begin
      r_s = dither_sat(r1_r, d1_r);
      g_s = dither_sat(g1_r, d1_r);
      b_s = dither_sat(b1_r, d1_r);
    end
  end

  // Stage 2: registered outputs.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      hd2_r  <= 1'b0;
      vd2_r  <= 1'b0;
      den2_r <= 1'b0;
      r2_r   <= 6'd0;
      g2_r   <= 6'd0;
      b2_r   <= 6'd0;
    end else begin
      hd2_r  <= hd1_r;
      vd2_r  <= vd1_r;
      den2_r <= den1_r;
      r2_r   <= r_s;
      g2_r   <= g_s;
      b2_r   <= b_s;
    end
  end

  assign pix.oHD    = hd2_r;
  assign pix.oVD    = vd2_r;
  assign pix.oDEN   = den2_r;
  assign pix.oLCD_R = r2_r;
  assign pix.oLCD_G = g2_r;
  assign pix.oLCD_B = b2_r;

endmodule

// File: tb/tb_lcd_dither_stage.sv
// Scoreboard bench for lcd_dither_stage (2x2 matrix); expectations come from a
// behavioural position/frame model, with temporal rotation when TEMPORAL_DITHER_EN is set.
module tb_lcd_dither_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  lcd_dither_if bus ();

  lcd_dither_stage #(.MATRIX_SIZE(2)) dut (
    .iCLK   (clk),
    .iRST_n (rst_n),
    .pix    (bus)
  );

  typedef logic [20:0] obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   m_xc, m_yc, m_fc;
  bit   m_den_prev, m_vd_prev;
  int   dmat[4] = '{0, 2, 3, 1};

  function automatic obs_t observe();
    return {bus.oHD, bus.oVD, bus.oDEN, bus.oLCD_R, bus.oLCD_G, bus.oLCD_B};
  endfunction

  function automatic int chan(int v, int d, bit byp, bit den);
    int q;
    if (!den) return 0;
    if (byp) return v / 4;
    q = (v + d) / 4;
    return (q > 63) ? 63 : q;
  endfunction

  task automatic check(input string tag, input obs_t expv);
    obs_t got;
    got = observe();
    vectors++;
    assert (got === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, expv);
    end
  endtask

  task automatic model_reset();
    m_xc = 0; m_yc = 0; m_fc = 0;
    m_den_prev = 1'b0; m_vd_prev = 1'b0;
    exp_q.delete();
    exp_q.push_back('0);
  endtask

  // Drive one pixel cycle, queue its expected output, check the output due now.
  task automatic step(input string tag, input bit hd, input bit vd, input bit den,
                      input int r, input int g, input int b, input bit byp);
    int xi, yi, d;
    bit vd_fall, den_fall;
    obs_t e;
    bus.iHD = hd; bus.iVD = vd; bus.iDEN = den; bus.iBYPASS = byp;
    bus.iLCD_R = 8'(r); bus.iLCD_G = 8'(g); bus.iLCD_B = 8'(b);
    xi = m_xc; yi = m_yc;
`ifdef TEMPORAL_DITHER_EN
    xi = m_xc ^ (m_fc & 1);
    yi = m_yc ^ ((m_fc >> 1) & 1);
`endif
    d = dmat[(yi % 2) * 2 + (xi % 2)];
    e = {hd, vd, den, 6'(chan(r, d, byp, den)), 6'(chan(g, d, byp, den)), 6'(chan(b, d, byp, den))};
    exp_q.push_back(e);
    vd_fall  = m_vd_prev && !vd;
    den_fall = m_den_prev && !den;
    m_xc = den ? (m_xc + 1) % 4 : 0;
    if (vd_fall) m_yc = 0;
    else if (den_fall) m_yc = (m_yc + 1) % 4;
    if (vd_fall) m_fc = (m_fc + 1) % 4;
    m_vd_prev = vd; m_den_prev = den;
    @(negedge clk);
    check(tag, exp_q.pop_front());
  endtask

  task automatic blank(input string tag, input int n);
    for (int i = 0; i < n; i++)
      step(tag, (i == 0), 1'b1, 1'b0, $urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 255), 1'b0);
  endtask

  task automatic line(input string tag, input int n, input int v, input bit byp);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b1, 1'b1, v, v, v, byp);
  endtask

  task automatic rline(input string tag, input int n);
    for (int i = 0; i < n; i++)
      step(tag, 1'b0, 1'b1, 1'b1, $urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 255), 1'($urandom_range(0, 1)));
  endtask

  task automatic vsync();
    step("vsync", 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1 check("rst_mid", '0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bus.iHD = 1'b0; bus.iVD = 1'b1; bus.iDEN = 1'b0; bus.iBYPASS = 1'b0;
    bus.iLCD_R = 8'd0; bus.iLCD_G = 8'd0; bus.iLCD_B = 8'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check("reset", '0);
    end
    rst_n = 1'b1;
    model_reset();

    vsync();
    blank("pre", 2);
    line("t1_l0", 8, 8'h81, 1'b0);
    blank("hb", 3);
    line("t1_l1", 8, 8'h81, 1'b0);
    blank("hb", 3);
    line("t2_l2", 4, 8'hFF, 1'b0);
    blank("hb", 3);
    line("t2_sat", 4, 8'hFF, 1'b0);
    blank("hb", 3);
    line("t3_byp81", 6, 8'h81, 1'b1);
    blank("hb", 2);
    line("t3_byp03", 6, 8'h03, 1'b1);
    blank("t4_pre", 4);
    step("t4_pulse", 1'b0, 1'b1, 1'b1, 8'h40, 8'h40, 8'h40, 1'b0);
    blank("t4_post", 4);
    rline("rnd0", 7);
    blank("hb", 2);
    rline("rnd1", 5);
    blank("hb", 2);

    vsync();
    blank("t5_pre", 2);
    line("t5_l0", 4, 8'h81, 1'b0);
    blank("hb", 3);
    line("t5_l1", 4, 8'h81, 1'b0);
    blank("hb", 3);

    rline("t6_pre", 3);
    do_reset(3);
    line("t6_post", 5, 8'h81, 1'b0);
    blank("hb", 3);
    line("t6_l1", 4, 8'h81, 1'b0);
    blank("flush", 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
